// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: load / capture / unload sequencer for one scan chain.
// Shifts a stimulus pattern in MSB first, drops scan_en for the capture
// window, shifts the response out into captured and compares it against
// the golden value.
// Optional feature macro: SCAN_CTRL_FAIL_CNT_EN (saturating fail counter).
// Without it fail_count is tied to zero.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN      = 4,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 chain_so,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [7:0]           fail_count
);

    localparam int unsigned CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CHAIN_LEN-1:0] pattern_q;
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CHAIN_LEN-1:0] cap_next;
    logic [CHAIN_LEN-1:0] pat_sh;
    logic                 accept;
    logic                 unload_end;

    // Response register value after the current unload shift.
    assign cap_next   = {captured[CHAIN_LEN-2:0], chain_so};
    assign accept     = (state_q == S_IDLE) && start;
    assign unload_end = (state_q == S_UNLOAD) && (state_d == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD;
            S_LOAD:    if (cnt_q == SHIFT_LAST) state_d = S_CAPTURE;
            S_CAPTURE: if (cnt_q == CAP_LAST) state_d = S_UNLOAD;
            S_UNLOAD:  if (cnt_q == SHIFT_LAST) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Moore output decode from state and counter.
    always_comb begin
        scan_en = 1'b0;
        scan_in = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        pat_sh  = pattern_q << cnt_q;
        case (state_q)
            S_LOAD: begin
                scan_en = 1'b1;
                scan_in = pat_sh[CHAIN_LEN-1];
                busy    = 1'b1;
            end
            S_CAPTURE: begin
                busy = 1'b1;
            end
            S_UNLOAD: begin
                scan_en = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Per-state cycle counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Test operands, response capture and pass flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q  <= '0;
            expected_q <= '0;
            captured   <= '0;
            pass       <= 1'b0;
        end else begin
            if (accept) begin
                pattern_q  <= pattern;
                expected_q <= expected;
                pass       <= 1'b0;
            end
            if ((state_q == S_UNLOAD) && !abort) begin
                captured <= cap_next;
            end
            if (unload_end) begin
                pass <= (cap_next == expected_q);
            end
        end
    end

`ifdef SCAN_CTRL_FAIL_CNT_EN
    // Saturating count of failed tests, counted on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_count <= 8'd0;
        end else if (unload_end && (cap_next != expected_q) && (fail_count != 8'hFF)) begin
            fail_count <= fail_count + 8'd1;
        end
    end
`else
    assign fail_count = 8'd0;
`endif

endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
Sequencer for a single scan chain such as the 4-bit ALU result register. It runs one scan test per start:
- Shifts a stimulus pattern into the chain.
- Releases scan_en for capture so the datapath loads its functional result.
- Shifts the response out and compares it against an expected value.

It sits between the test access logic (pattern source, pass/fail sink) and the scan_en/scan_in/scan_out pins of the chain.

Parameters:
- CHAIN_LEN, 4, number of flops in the chain; minimum 2.
- CAPTURE_CYCLES, 1, functional cycles with scan_en=0 between load and unload; minimum 1.

Ports:
- clk  input  1  single clock, shared with the scanned block.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request one test; sampled in IDLE only.
- abort  input  1  return to IDLE immediately; no done pulse.
- pattern  input  CHAIN_LEN  stimulus; latched when start is accepted.
- expected  input  CHAIN_LEN  golden response; latched when start is accepted.
- chain_so  input  1  scan_out of the chain (chain MSB).
- scan_en  output  1  drives the chain scan_en.
- scan_in  output  1  drives the chain scan_in.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- pass  output  1  captured == expected; valid from done until the next accepted start.
- captured  output  CHAIN_LEN  unloaded response, MSB = first bit shifted out.
- fail_count  output  8  see Optional Feature.

Behaviour:
- Chain model: scanned block shifts left, scan_in enters bit 0, scan_out = bit CHAIN_LEN-1.
- FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE. Cycle counter width is clog2(max(CHAIN_LEN, CAPTURE_CYCLES)).
- Outputs scan_en, scan_in, busy and done are decoded from the state and counter registers (Moore); there are no combinational paths from inputs.
- IDLE:
  - scan_en=0, scan_in=0, busy=0.
  - start=1 at an edge: latch pattern and expected, clear counter, go to LOAD, clear pass.
- LOAD (CHAIN_LEN cycles, cnt 0..CHAIN_LEN-1):
  - scan_en=1, scan_in = pattern_q[CHAIN_LEN-1-cnt], i.e. MSB first.
  - After the last shift the chain holds pattern_q exactly.
- CAPTURE (CAPTURE_CYCLES cycles):
  - scan_en=0, scan_in=0; the chain loads its functional value.
- UNLOAD (CHAIN_LEN cycles):
  - scan_en=1, scan_in=0.
  - Each edge: captured <= {captured[CHAIN_LEN-2:0], chain_so}.
  - After the last edge, captured equals the chain contents at the end of capture.
- DONE (1 cycle):
  - done=1, busy=1, scan_en=0.
  - pass is registered on entry: pass = (captured == expected_q).
  - Next state is IDLE.
- Latency: with start accepted at edge t, done is high during cycle t + 2*CHAIN_LEN + CAPTURE_CYCLES + 1. Defaults give 10 cycles.
- start while busy is ignored and not queued. start in the DONE cycle is ignored; the earliest restart is the first IDLE cycle.
- abort=1 in any non-IDLE state: IDLE at the next edge.
  - scan_en drops that cycle.
  - captured and pass keep their old values; done is not pulsed.
  - abort has priority over start and over all state transitions.
- Reset (asynchronous, any state including mid-LOAD/UNLOAD):
  - State goes to IDLE.
  - scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, fail_count=0.
  - Latched pattern/expected are cleared to 0.
- Chain contents after a test are the shifted-in zeros; the controller never restores them.

Optional Feature:
SCAN_CTRL_FAIL_CNT_EN
- Defined: fail_count increments on every DONE cycle with pass=0. It saturates at 255 and is cleared only by rst.
- Not defined: fail_count is tied to 8'd0 and no counter flops are inferred. The port is always present.

Test Plan:
- Stimulus: reset release, then start with pattern=4'b1011; ALU op_code=00, A=3, B=5; expected=4'b1000.
  Response: scan_in sequence 1,0,1,1 during LOAD; scan_en=0 for exactly 1 cycle; done in cycle 10; captured=4'b1000, pass=1.
- Stimulus: same test with expected=4'b0111.
  Response: captured=4'b1000, pass=0; fail_count=1 with the macro, 0 without.
- Stimulus: op_code=11, A=4'b1010, B=4'b0101, expected=4'b1111; pulse start again during UNLOAD.
  Response: single done; pass=1; second start ignored; busy continuous through DONE.
- Stimulus: abort asserted on LOAD cycle 2.
  Response: busy=0 and scan_en=0 next cycle; no done; captured/pass unchanged; a subsequent start runs a full 10-cycle test.
- Stimulus: rst low mid-UNLOAD.
  Response: all outputs 0 asynchronously; after release the FSM stays in IDLE until start.
- Stimulus: CHAIN_LEN=8, CAPTURE_CYCLES=2 with an 8-bit shift-register dummy chain loading 8'hA5 in capture; expected 8'hA5.
  Response: done in cycle 19; captured=8'hA5, pass=1.
